match_timer_bcd: RTL and testbench

- Match countdown timer for the game HUD; counts down mm:ss in BCD at 1 Hz.
- Feeds the four digit inputs of the 7-segment scan driver (min_ten, min_one, sec_ten, sec_one).
- Driven by game-control start, pause and load commands.
- Flags match end with a level output and a one-cycle pulse.

---
 rtl/match_timer_bcd.sv | 140 ++++++++++++++
 tb/tb_match_timer_bcd.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/match_timer_bcd.sv
// Match countdown timer: mm:ss in BCD, decremented once per TICK_DIV clocks while running.
// Single-cycle start/pause/load commands; a one-cycle time_up pulse accompanies the 00:00 update.
module match_timer_bcd #(
    parameter int TICK_DIV     = 100000000,
    parameter int INIT_MIN_TEN = 0,
    parameter int INIT_MIN_ONE = 3,
    parameter int INIT_SEC_TEN = 0,
    parameter int INIT_SEC_ONE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    output logic [3:0] min_ten,
    output logic [3:0] min_one,
    output logic [3:0] sec_ten,
    output logic [3:0] sec_one,
    output logic       running,
    output logic       expired,
    output logic       time_up
);

    localparam int             PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  TICK_MAX = PW'(TICK_DIV - 1);
    localparam logic [3:0]     P_MT     = 4'(INIT_MIN_TEN);
    localparam logic [3:0]     P_MO     = 4'(INIT_MIN_ONE);
    localparam logic [3:0]     P_ST     = 4'(INIT_SEC_TEN);
    localparam logic [3:0]     P_SO     = 4'(INIT_SEC_ONE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_EXPIRED} state_t;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic [3:0]    r_mt, r_mo, r_st, r_so;
    logic [3:0]    w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt;
    logic [3:0]    w_dec_mt, w_dec_mo, w_dec_st, w_dec_so;
    logic          w_b_so, w_b_st, w_b_mo;
    logic          r_time_up, w_time_up_nxt;
    logic          w_is_zero, w_dec_zero, w_tick;

    // BCD borrow chain; seconds tens wraps to 5, all other digits to 9
    assign w_b_so   = (r_so == 4'd0);
    assign w_dec_so = w_b_so ? 4'd9 : r_so - 4'd1;
    assign w_b_st   = w_b_so && (r_st == 4'd0);
    assign w_dec_st = !w_b_so ? r_st : ((r_st == 4'd0) ? 4'd5 : r_st - 4'd1);
    assign w_b_mo   = w_b_st && (r_mo == 4'd0);
    assign w_dec_mo = !w_b_st ? r_mo : ((r_mo == 4'd0) ? 4'd9 : r_mo - 4'd1);
    assign w_dec_mt = w_b_mo ? r_mt - 4'd1 : r_mt;

    assign w_is_zero  = ({r_mt, r_mo, r_st, r_so} == 16'd0);
    assign w_dec_zero = ({w_dec_mt, w_dec_mo, w_dec_st, w_dec_so} == 16'd0);
    assign w_tick     = (r_presc == TICK_MAX);

    always_comb begin
        w_state_nxt   = r_state;
        w_presc_nxt   = r_presc;
        w_mt_nxt      = r_mt;
        w_mo_nxt      = r_mo;
        w_st_nxt      = r_st;
        w_so_nxt      = r_so;
        w_time_up_nxt = 1'b0;
        if (load) begin
            w_state_nxt = S_IDLE;
            w_presc_nxt = '0;
            w_mt_nxt    = P_MT;
            w_mo_nxt    = P_MO;
            w_st_nxt    = P_ST;
            w_so_nxt    = P_SO;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !pause) begin
                        if (w_is_zero) begin
                            w_state_nxt   = S_EXPIRED;
                            w_time_up_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_RUN;
                            w_presc_nxt = '0;
                        end
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        w_state_nxt = S_PAUSE;
                    end else if (w_tick) begin
                        w_presc_nxt = '0;
                        w_mt_nxt    = w_dec_mt;
                        w_mo_nxt    = w_dec_mo;
                        w_st_nxt    = w_dec_st;
                        w_so_nxt    = w_dec_so;
                        if (w_dec_zero) begin
                            w_state_nxt   = S_EXPIRED;
                            w_time_up_nxt = 1'b1;
                        end
                    end else begin
                        w_presc_nxt = r_presc + 1'b1;
                    end
                end
                S_PAUSE: begin
                    // prescaler is left untouched so the partial second survives
                    if (start && !pause) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_mt      <= P_MT;
            r_mo      <= P_MO;
            r_st      <= P_ST;
            r_so      <= P_SO;
            r_time_up <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_mt      <= w_mt_nxt;
            r_mo      <= w_mo_nxt;
            r_st      <= w_st_nxt;
            r_so      <= w_so_nxt;
            r_time_up <= w_time_up_nxt;
        end
    end

    assign min_ten = r_mt;
    assign min_one = r_mo;
    assign sec_ten = r_st;
    assign sec_one = r_so;
    assign running = (r_state == S_RUN);
    assign expired = (r_state == S_EXPIRED);
    assign time_up = r_time_up;

endmodule

// File: tb/tb_match_timer_bcd.sv
// Five timers with different presets share one command stream; a seconds-count model predicts every cycle.
module tb_match_timer_bcd;

    localparam int N  = 5;
    localparam int TD = 4;
    // presets as BCD mm:ss: 00:00, 00:02, 10:00, 01:00, 03:00 (instance 0 is the lowest slot)
    localparam logic [16*N-1:0] PRESETS = {16'h0000, 16'h0002, 16'h1000, 16'h0100, 16'h0300};
    localparam int IDLE = 0, RUN = 1, PAUSED = 2, EXPD = 3;

    logic clk = 1'b0;
    logic rst = 1'b0, start = 1'b0, pause = 1'b0, load = 1'b0;
    logic [3:0] mt [N];
    logic [3:0] mo [N];
    logic [3:0] sd [N];
    logic [3:0] so [N];
    logic run_o [N];
    logic exp_o [N];
    logic tu_o  [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        match_timer_bcd #(
            .TICK_DIV    (TD),
            .INIT_MIN_TEN(int'(PRESETS[16*g+12 +: 4])),
            .INIT_MIN_ONE(int'(PRESETS[16*g+8 +: 4])),
            .INIT_SEC_TEN(int'(PRESETS[16*g+4 +: 4])),
            .INIT_SEC_ONE(int'(PRESETS[16*g +: 4]))
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .start  (start),
            .pause  (pause),
            .load   (load),
            .min_ten(mt[g]),
            .min_one(mo[g]),
            .sec_ten(sd[g]),
            .sec_one(so[g]),
            .running(run_o[g]),
            .expired(exp_o[g]),
            .time_up(tu_o[g])
        );
    end

    int m_secs [N];
    int m_st   [N];
    int m_pc   [N];
    bit m_tu   [N];
    logic [19*N-1:0] exp_q [$];
    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    function automatic int preset_secs(input int g);
        logic [15:0] p;
        p = PRESETS[16*g +: 16];
        return int'(p[15:12]) * 600 + int'(p[11:8]) * 60 + int'(p[7:4]) * 10 + int'(p[3:0]);
    endfunction

    function automatic logic [18:0] expect_of(input int g);
        int m, s;
        m = m_secs[g] / 60;
        s = m_secs[g] % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                m_st[g] == RUN, m_st[g] == EXPD, m_tu[g]};
    endfunction

    // Remaining time is kept as a plain seconds count; BCD digits are derived only for comparison.
    task automatic model_step();
        logic [19*N-1:0] v;
        for (int g = 0; g < N; g++) begin
            m_tu[g] = 1'b0;
            if (rst || load) begin
                m_secs[g] = preset_secs(g);
                m_st[g]   = IDLE;
                m_pc[g]   = 0;
            end else if (m_st[g] == IDLE) begin
                if (start && !pause) begin
                    if (m_secs[g] == 0) begin
                        m_st[g] = EXPD;
                        m_tu[g] = 1'b1;
                    end else begin
                        m_st[g] = RUN;
                        m_pc[g] = 0;
                    end
                end
            end else if (m_st[g] == RUN) begin
                if (pause) begin
                    m_st[g] = PAUSED;
                end else begin
                    m_pc[g] = (m_pc[g] + 1) % TD;
                    if (m_pc[g] == 0) begin
                        m_secs[g] = m_secs[g] - 1;
                        if (m_secs[g] == 0) begin
                            m_st[g] = EXPD;
                            m_tu[g] = 1'b1;
                        end
                    end
                end
            end else if (m_st[g] == PAUSED) begin
                if (start && !pause) m_st[g] = RUN;
            end
            v[19*g +: 19] = expect_of(g);
        end
        exp_q.push_back(v);
    endtask

    task automatic cycle(input logic r, input logic s, input logic p, input logic l);
        @(negedge clk);
        rst = r; start = s; pause = p; load = l;
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        logic [19*N-1:0] e;
        logic [18:0] got, want;
        cyc <= cyc + 1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int g = 0; g < N; g++) begin
                want = e[19*g +: 19];
                got  = {mt[g], mo[g], sd[g], so[g], run_o[g], exp_o[g], tu_o[g]};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL timer%0d cyc%0d: got %h%h:%h%h run=%b exp=%b tu=%b, want %h%h:%h%h run=%b exp=%b tu=%b",
                             g, cyc, got[18:15], got[14:11], got[10:7], got[6:3], got[2], got[1], got[0],
                             want[18:15], want[14:11], want[10:7], want[6:3], want[2], want[1], want[0]);
                end
            end
        end
    end

    task automatic run_until_pc(input int target);
        int n;
        n = 0;
        while (!(m_st[0] == RUN && m_pc[0] == target) && n < 50) begin
            idle(1);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL align_prescaler: waited %0d cycles, need pc=%0d in RUN", n, target);
        end
    endtask

    initial begin
        int n;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(10);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(10);
        // pause after two prescaler counts, hold, then resume
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(6);
        run_until_pc(3);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        // run the 3:00 timer down to 1:37, then load mid-count
        n = 0;
        while (m_secs[0] != 97 && n < 2000) begin
            idle(1);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL reach_1_37: waited %0d cycles, secs=%0d need 97", n, m_secs[0]);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (m_st[0] != EXPD && n < 1000) begin
            idle(1);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL reach_expiry: waited %0d cycles, state=%0d need %0d", n, m_st[0], EXPD);
        end
        idle(3);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 999) < 3),  1'($urandom_range(0, 99) < 6),
                  1'($urandom_range(0, 99) < 3),   1'($urandom_range(0, 999) < 8));
        end
        idle(2);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, need 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
